// File: rtl/fa.sv
// 1-bit full adder cell with generate/propagate outputs and a registered sum/carry copy.
// Optional redundant mux-based adder with sticky mismatch flag when FA_SELFCHECK_EN is defined.
module fa (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co,
    output logic g,
    output logic p,
    output logic s_q,
    output logic co_q,
    output logic err
);

    logic s_d;
    logic co_d;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        s    = p ^ ci;
        co   = g | (p & ci);
        s_d  = s;
        co_d = co;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= 1'b0;
            co_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

`ifdef FA_SELFCHECK_EN
    // Structurally different adder: any disagreement with the main path latches err.
    logic s2;
    logic co2;
    logic err_d;
    logic err_q;

    always_comb begin
        s2    = ci ? ~(a ^ b) : (a ^ b);
        co2   = (a ^ b) ? ci : a;
        err_d = err_q | (s != s2) | (co != co2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fa.sv
// Scoreboard bench for fa: combinational truth table, registered path, reset and error flag.
module tb_fa;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic ci;
    logic s;
    logic co;
    logic g;
    logic p;
    logic s_q;
    logic co_q;
    logic err;

    int n_cmp;
    int n_err;

    logic [3:0] comb_q[$];
    logic [2:0] reg_q[$];

    fa dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .ci  (ci),
        .s   (s),
        .co  (co),
        .g   (g),
        .p   (p),
        .s_q (s_q),
        .co_q(co_q),
        .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Reference model: arithmetic sum, independent of gate structure.
    function automatic logic [3:0] model_comb(input logic ma, input logic mb, input logic mc);
        logic [1:0] sum;
        sum = 2'(ma) + 2'(mb) + 2'(mc);
        return {sum[0], sum[1], ma & mb, ma ^ mb};
    endfunction

    task automatic check_comb(input string tag);
        logic [3:0] e;
        comb_q.push_back(model_comb(a, b, ci));
        #1;
        e = comb_q.pop_front();
        chk(tag, {s, co, g, p}, e);
    endtask

    // One cycle: drive at negedge, check comb, capture at posedge, check registers.
    task automatic step(input string tag, input logic r, input logic [2:0] abc);
        logic [3:0] m;
        logic [2:0] e;
        @(negedge clk);
        rst = r;
        {a, b, ci} = abc;
        check_comb({tag, "_comb"});
        m = model_comb(abc[2], abc[1], abc[0]);
        reg_q.push_back(r ? 3'b000 : {m[3], m[2], 1'b0});
        @(posedge clk);
        #1;
        e = reg_q.pop_front();
        chk({tag, "_reg"}, {1'b0, s_q, co_q, err}, {1'b0, e});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        {a, b, ci} = 3'b000;

        // Exhaustive combinational sweep, 10 ns per vector.
        for (int v = 0; v < 8; v++) begin
            {a, b, ci} = 3'(v);
            check_comb($sformatf("comb_%0d", v));
            #9;
        end

        {a, b, ci} = 3'b110;
        check_comb("dir_110");
        chk("dir_110_vals", {s, co, g, p}, 4'b0110);
        {a, b, ci} = 3'b011;
        check_comb("dir_011");
        chk("dir_011_vals", {s, co, g, p}, 4'b0101);

        // Two reset edges with all inputs high.
        step("rst1", 1'b1, 3'b111);
        step("rst2", 1'b1, 3'b111);
        chk("rst_comb_high", {2'b00, s, co}, 4'b0011);

        // Edge N captures 101, then a mid-cycle change must not disturb the registers.
        step("edgeN", 1'b0, 3'b101);
        chk("edgeN_vals", {2'b00, s_q, co_q}, 4'b0001);
        #2;
        {a, b, ci} = 3'b000;
        #1;
        chk("midcycle_hold", {2'b00, s_q, co_q}, 4'b0001);
        check_comb("midcycle_comb");
        step("next_000", 1'b0, 3'b000);

        // Glitchy inputs before an edge: only the last value counts.
        @(negedge clk);
        {a, b, ci} = 3'b111;
        #1 {a, b, ci} = 3'b001;
        #1 {a, b, ci} = 3'b010;
        step("glitch_last", 1'b0, 3'b110);

        // Mid-stream reset with 111, then release.
        step("rst_mid", 1'b1, 3'b111);
        step("rst_rel", 1'b0, 3'b111);
        chk("rst_rel_vals", {2'b00, s_q, co_q}, 4'b0011);

        // All vectors clocked: err must stay low throughout.
        for (int v = 0; v < 8; v++) begin
            step($sformatf("walk_%0d", v), 1'b0, 3'(v));
        end
        for (int v = 0; v < 8; v++) begin
            step($sformatf("rand_%0d", v), 1'b0, 3'($urandom_range(0, 7)));
        end
        chk("err_final", {3'b000, err}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
